// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed common-anode seven-segment scan driver for a packed BCD word.
// One digit per refresh slot, with leading-zero blanking, decimal points and a frame pulse.
module bcd_sevenseg_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [BCD_W-1:0]  disp_val;
  logic [DIGITS-1:0] disp_dp;
  logic [PRE_W-1:0]  presc;
  logic [IDX_W-1:0]  idx;
  logic              wrap_pend;

  logic [DIGITS-1:0] an_c;
  logic [DIGITS-1:0] lz_c;
  logic [6:0]        seg_c;
  logic [3:0]        nib_c;
  logic              dp_c;
  logic              dpbit_c;
  logic              blank_c;
  logic              zero_above_c;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Select the current digit and decide whether it is a blanked leading zero.
  always_comb begin
    an_c         = '1;
    lz_c         = '0;
    nib_c        = 4'd0;
    dpbit_c      = 1'b0;
    blank_c      = 1'b0;
    zero_above_c = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_above_c = zero_above_c & (disp_val[4*k +: 4] == 4'd0);
      lz_c[k]      = zero_above_c;
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IDX_W'(k)) begin
        an_c[k] = 1'b0;
        nib_c   = disp_val[4*k +: 4];
        dpbit_c = disp_dp[k];
        blank_c = blank_lz & lz_c[k];
      end
    end
    seg_c = blank_c ? 7'b1111111 : decode(nib_c);
    dp_c  = ~dpbit_c;
  end

  // Display register, prescaler/digit index and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      presc      <= '0;
      idx        <= '0;
      wrap_pend  <= 1'b0;
      an         <= '1;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        disp_val <= bcd_in;
        disp_dp  <= dp_mask;
      end
      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        presc <= presc + PRE_W'(1);
      end
      // Flags the frame start so the pulse lines up with the first digit-0 output cycle.
      wrap_pend  <= (presc == PRE_LAST) && (idx == IDX_LAST);
      an         <= an_c;
      seg        <= seg_c;
      dp         <= dp_c;
      frame_done <= wrap_pend;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan (DIGITS=4, REFRESH_DIV=4).
// A cycle model pushes expected outputs per edge; each test pops and compares.
module tb_bcd_sevenseg_scan;

  localparam int unsigned DIG = 4;
  localparam int unsigned DIV = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  exp_t        sb[$];
  exp_t        o;
  int          cnt = 0;
  logic [15:0] sh_val = 16'h0000;
  logic [3:0]  sh_dp = 4'b0000;
  int          total = 0;
  int          passed = 0;

  bcd_sevenseg_scan #(.DIGITS(DIG), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return t[n];
  endfunction

  // Expected output for the coming edge, from the inputs now applied and the shadow state.
  function automatic exp_t model();
    exp_t        e;
    int          d;
    logic [15:0] upper;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      return e;
    end
    d      = (cnt / DIV) % DIG;
    upper  = sh_val >> (4 * d);
    e.an   = ~(4'b0001 << d);
    e.seg  = (blank_lz && d >= 1 && upper == 16'h0) ? 7'h7F : seg_of(sh_val[4*d +: 4]);
    e.dp   = ~sh_dp[d];
    e.fd   = (cnt > 0) && (cnt % (DIV * DIG) == 0);
    return e;
  endfunction

  task automatic advance();
    sb.push_back(model());
    @(posedge clk);
    if (rst) begin
      cnt = 0; sh_val = 16'h0; sh_dp = 4'h0;
    end else begin
      cnt++;
      if (load) begin sh_val = bcd_in; sh_dp = dp_mask; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; bcd_in = 16'h9999; dp_mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      advance();
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0} || o !== {4'hF, 7'h7F, 1'b1, 1'b0})
        $display("FAIL reset_hold: got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0", an, seg, dp, frame_done);
      else passed++;
    end
    rst = 1'b0; load = 1'b0; dp_mask = 4'h0;
    advance();
    o = sb.pop_front();
    total++;
    if ({an, seg, dp, frame_done} !== {4'b1110, 7'b1000000, 1'b1, 1'b0} || o !== {4'b1110, 7'b1000000, 1'b1, 1'b0})
      $display("FAIL reset_exit: got an=%b seg=%b dp=%b fd=%b want an=1110 seg=1000000 dp=1 fd=0", an, seg, dp, frame_done);
    else passed++;
  endtask

  task automatic test_scan();
    int         fds = 0;
    logic [6:0] want;
    blank_lz = 1'b0; bcd_in = 16'h1234; dp_mask = 4'h0; load = 1'b1;
    advance(); load = 1'b0;
    o = sb.pop_front();
    for (int i = 0; i < 32; i++) begin
      advance();
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o)
        $display("FAIL scan: cnt=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b", cnt, an, seg, dp, frame_done, o.an, o.seg, o.dp, o.fd);
      else passed++;
      case (an)
        4'b1110: want = 7'b0011001;
        4'b1101: want = 7'b0110000;
        4'b1011: want = 7'b0100100;
        4'b0111: want = 7'b1111001;
        default: want = 7'bxxxxxxx;
      endcase
      total++;
      if (seg !== want) $display("FAIL scan_digit: an=%b got seg=%b want %b", an, seg, want);
      else passed++;
      if (frame_done) begin
        fds++;
        total++;
        if (an !== 4'b1110) $display("FAIL scan_fd_anode: got an=%b want 1110", an);
        else passed++;
      end
    end
    total++;
    if (fds !== 2) $display("FAIL scan_fd_count: got %0d pulses in 32 cycles want 2", fds);
    else passed++;
  endtask

  task automatic test_blank();
    logic [15:0] words [3];
    words = '{16'h0047, 16'h0000, 16'h0407};
    blank_lz = 1'b1; dp_mask = 4'h0;
    foreach (words[w]) begin
      bcd_in = words[w]; load = 1'b1;
      advance(); load = 1'b0;
      o = sb.pop_front();
      for (int i = 0; i < 16; i++) begin
        advance();
        o = sb.pop_front();
        total++;
        if ({an, seg, dp, frame_done} !== o)
          $display("FAIL blank_%h: cnt=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b", words[w], cnt, an, seg, dp, frame_done, o.an, o.seg, o.dp, o.fd);
        else passed++;
        if (words[w] == 16'h0407 && an == 4'b1101) begin
          total++;
          if (seg !== 7'b1000000) $display("FAIL blank_inner_zero: got seg=%b want 1000000", seg);
          else passed++;
        end
        if (words[w] == 16'h0047 && (an == 4'b0111 || an == 4'b1011)) begin
          total++;
          if (seg !== 7'b1111111) $display("FAIL blank_lead: an=%b got seg=%b want 1111111", an, seg);
          else passed++;
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp_invalid();
    bcd_in = 16'h00A5; dp_mask = 4'b0010; load = 1'b1;
    advance(); load = 1'b0;
    o = sb.pop_front();
    for (int i = 0; i < 16; i++) begin
      advance();
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o)
        $display("FAIL dp_invalid: cnt=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b", cnt, an, seg, dp, frame_done, o.an, o.seg, o.dp, o.fd);
      else passed++;
      total++;
      if (dp !== (an != 4'b1101)) $display("FAIL dp_bit: an=%b got dp=%b want %b", an, dp, an != 4'b1101);
      else passed++;
    end
  endtask

  task automatic test_midslot_load();
    bcd_in = 16'h0009; dp_mask = 4'h0; load = 1'b1;
    advance(); load = 1'b0;
    o = sb.pop_front();
    for (int i = 0; i < 20 && (cnt % 16) != 1; i++) begin
      advance();
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o)
        $display("FAIL midslot_align: cnt=%0d got an=%b seg=%b want an=%b seg=%b", cnt, an, seg, o.an, o.seg);
      else passed++;
    end
    bcd_in = 16'h0008; load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance(); load = 1'b0;
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o)
        $display("FAIL midslot: step=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b", i, an, seg, dp, frame_done, o.an, o.seg, o.dp, o.fd);
      else passed++;
      if (i < 2) begin
        total++;
        if (an !== 4'b1110 || seg !== ((i == 0) ? 7'b0010000 : 7'b0000000))
          $display("FAIL midslot_latency: step=%0d got an=%b seg=%b", i, an, seg);
        else passed++;
      end
    end
  endtask

  task automatic test_load_at_wrap();
    bcd_in = 16'h1234; load = 1'b1;
    advance(); load = 1'b0;
    o = sb.pop_front();
    for (int i = 0; i < 8 && (cnt % DIV) != DIV - 1; i++) begin
      advance();
      o = sb.pop_front();
    end
    bcd_in = 16'h5678; load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      advance(); load = 1'b0;
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o)
        $display("FAIL load_at_wrap: cnt=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b", cnt, an, seg, dp, frame_done, o.an, o.seg, o.dp, o.fd);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20 && (cnt % 16) != 9; i++) begin
      advance();
      o = sb.pop_front();
    end
    total++;
    if (an !== 4'b1011) $display("FAIL rstmid_setup: got an=%b want 1011", an);
    else passed++;
    rst = 1'b1; load = 1'b1; bcd_in = 16'h9999;
    advance();
    rst = 1'b0; load = 1'b0;
    o = sb.pop_front();
    total++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL rstmid_values: got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0", an, seg, dp, frame_done);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      advance();
      o = sb.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== o || seg !== 7'b1000000 || an !== ((i < 4) ? 4'b1110 : 4'b1101))
        $display("FAIL rstmid_slot: step=%0d got an=%b seg=%b fd=%b want an=%b seg=1000000 fd=0", i, an, seg, frame_done, (i < 4) ? 4'b1110 : 4'b1101);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_dp_invalid();
    test_midslot_load();
    test_load_at_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
